// File: rtl/addsub_pkg.sv
// Shared constants, FSM state type and saturation helper for the digit-serial adder/subtractor.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest operand the saturation helper can describe.
    localparam int unsigned SatMaxW = 64;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    // Clamp value for a WIDTH-bit signed result: min negative when neg=1, else max positive.
    function automatic logic [SatMaxW-1:0] sat_value(input int unsigned width, input logic neg);
        logic [SatMaxW-1:0] top_bit;
        top_bit = SatMaxW'(1) << (width - 1);
        return neg ? top_bit : (top_bit - SatMaxW'(1));
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit adder slice; also exposes the carry into its top bit for overflow.
module digit_adder #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] x_i,
    input  logic [DIGIT-1:0] y_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] s_o,
    output logic             cout_o,
    output logic             c_msb_in_o
);

    logic [DIGIT:0] full;

    always_comb begin
        full       = {1'b0, x_i} + {1'b0, y_i} + {{DIGIT{1'b0}}, cin_i};
        s_o        = full[DIGIT-1:0];
        cout_o     = full[DIGIT];
        // Carry into the top bit recovered from the sum bit, valid for DIGIT=1 too.
        c_msb_in_o = full[DIGIT-1] ^ x_i[DIGIT-1] ^ y_i[DIGIT-1];
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement add/sub, DIGIT bits per cycle LSB first, start/busy/done handshake.
// Define ADDSUB_SATURATE_EN to clamp the sum on signed overflow.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             op_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             overflow_o,
    output logic             carry_out_o
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = $clog2(N) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
`ifdef ADDSUB_SATURATE_EN
    logic               a_msb_q, a_msb_d;
    logic [SatMaxW-1:0] sat_full;
`endif

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic             dig_cmsb;
    logic [WIDTH-1:0] res_shift;

    digit_adder #(
        .DIGIT(DIGIT)
    ) u_digit_adder (
        .x_i       (opa_q[DIGIT-1:0]),
        .y_i       (opb_q[DIGIT-1:0]),
        .cin_i     (carry_q),
        .s_o       (dig_s),
        .cout_o    (dig_cout),
        .c_msb_in_o(dig_cmsb)
    );

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res_d     = res_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        cout_d    = cout_q;
        done_d    = 1'b0;
        // New digit enters from the MSB side so the result is aligned after N shifts.
        res_shift = (res_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
`ifdef ADDSUB_SATURATE_EN
        a_msb_d   = a_msb_q;
        sat_full  = sat_value(WIDTH, a_msb_q);
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    opa_d   = a_i;
                    opb_d   = (op_i == OP_SUB) ? ~b_i : b_i;
                    carry_d = op_i;
                    cnt_d   = '0;
                    state_d = StRun;
`ifdef ADDSUB_SATURATE_EN
                    a_msb_d = a_i[WIDTH-1];
`endif
                end
            end
            StRun: begin
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                res_d   = res_shift;
                carry_d = dig_cout;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    sum_d   = res_shift;
                    cout_d  = dig_cout;
                    ovf_d   = dig_cmsb ^ dig_cout;
                    done_d  = 1'b1;
                    state_d = StIdle;
`ifdef ADDSUB_SATURATE_EN
                    if (dig_cmsb ^ dig_cout) begin
                        sum_d = sat_full[WIDTH-1:0];
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ADDSUB_SATURATE_EN
            a_msb_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
`ifdef ADDSUB_SATURATE_EN
            a_msb_q <= a_msb_d;
`endif
        end
    end

    assign busy_o      = (state_q == StRun);
    assign done_o      = done_q;
    assign sum_o       = sum_q;
    assign overflow_o  = ovf_q;
    assign carry_out_o = cout_q;

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised digit-serial two's-complement adder/subtractor; multi-cycle successor to the 8-bit ripple add/sub.
- Processes DIGIT bits per clock, LSB first, over WIDTH/DIGIT cycles.
- Uses a start/busy/done handshake and reports signed overflow and raw carry.
- Sits in the datapath where area matters more than single-cycle latency.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH; DIGIT=WIDTH gives a one-cycle op.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- a  in  WIDTH  operand A (signed two's complement)
- b  in  WIDTH  operand B (signed two's complement)
- op  in  1  0 = a+b, 1 = a-b
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; sum/overflow/carry_out valid
- sum  out  WIDTH  result; held until next accepted start
- overflow  out  1  signed overflow of last op
- carry_out  out  1  raw carry out of MSB (for sub, 1 = no borrow)

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: state IDLE; busy, done, overflow, carry_out = 0; sum = 0; digit counter = 0.
- Reset asserted mid-operation aborts it immediately. No done pulse follows; the next start is a fresh op.
- States: IDLE, RUN.
- IDLE → RUN on an edge with start=1. At that edge:
  - latch a into opa;
  - latch b into opb, or ~b when op=1;
  - carry register ← op;
  - counter ← 0; busy ← 1.
- start while busy=1 is ignored; operands are not relatched.
- RUN, each edge:
  - add opa[DIGIT-1:0] + opb[DIGIT-1:0] + carry through digit_adder;
  - shift opa and opb right by DIGIT;
  - shift the result digit into the result shift register from the MSB side;
  - carry ← digit carry; counter increments.
- On the edge completing digit N-1 (N = WIDTH/DIGIT):
  - sum ← final result; carry_out ← final carry;
  - overflow ← carry into MSB XOR carry out of MSB;
  - done ← 1 for exactly one cycle; busy ← 0; state → IDLE.
- Latency: start sampled at edge T0 → done high after edge T0+N.
- Back-to-back operation: start may be high in the done cycle. It is accepted at the next edge, giving throughput of one op per N+1 cycles.
- sum, overflow and carry_out are not disturbed during RUN. They update only at completion, so the previous result stays readable while busy.
- Width rules: all arithmetic is modulo 2^WIDTH. The carry register is 1 bit. The counter is $clog2(N)+1 bits, so N=1 is legal.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined: when overflow=1, sum is clamped at completion:
  - a_msb=0 → 0111..1 (max positive);
  - a_msb=1 → 1000..0 (min negative), where a_msb is the latched sign of a;
  - overflow is still reported as 1.
- Undefined: sum is the wrapped modulo result. The latched a_msb flop is not instantiated.

Decomposition:
- Package addsub_pkg:
  - OP_ADD=1'b0, OP_SUB=1'b1;
  - state enum type (IDLE, RUN);
  - function for saturation max/min as a function of WIDTH.
- Sub-module digit_adder: combinational, parameter DIGIT; inputs x, y, cin; outputs s, cout, and c_msb_in (carry into its top bit, used for the overflow calc on the final digit).
- serial_addsub holds the FSM, shift registers and counter.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x7F, b=0x01, op=0 → done 8 cycles after start; sum=0x80, overflow=1, carry_out=0 (sum=0x7F with ADDSUB_SATURATE_EN).
- WIDTH=8, DIGIT=1: a=0x05, b=0x07, op=1 → sum=0xFE, overflow=0, carry_out=0; a=0x80, b=0x01, op=1 → sum=0x7F, overflow=1, carry_out=1 (0x80 saturated).
- WIDTH=8, DIGIT=4: a=0x3C, b=0x44, op=0 → done 2 cycles after start; sum=0x80, overflow=1. WIDTH=16, DIGIT=16: 0xFFFF+0x0001 → sum=0x0000, carry_out=1, overflow=0, done after 1 cycle.
- Pulse start again 3 cycles into an op with different a/b → ignored; first result is unchanged and exactly one done pulse occurs.
- Drop rst_n in cycle 4 of an 8-cycle op → busy, done, sum, overflow, carry_out = 0 asynchronously; no later done; a new start after release gives the correct result.
- Hold start high continuously with changing operands → done pulses every 9 cycles (DIGIT=1) and each result matches its operands latched at acceptance.
